nbit_demux_reg: RTL
===================

# nbit_demux_reg

Registered 1-to-2 demultiplexer for N-bit data words with valid/ready handshaking on all three channels. It is the splitting counterpart of the N-bit 2:1 select path. It steers each accepted input word to output A (`in_sel`=0) or output B (`in_sel`=1) through a 2-entry FIFO per output. The pipeline uses it to route one shared producer, such as a unified memory response port, to two consumers (fetch and memory stages) without either consumer stalling the other.

## Interface
- `N`, default 32: data width in bits; legal range 1..64.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of both output FIFOs; has no effect on reset.
- `in_valid` in 1: input word present.
- `in_data` in N: input word.
- `in_sel` in 1: destination select, 0 = A, 1 = B; sampled with `in_data`.
- `in_ready` out 1: input word accepted this cycle when high together with `in_valid`.
- `a_valid` out 1, `a_data` out N, `a_ready` in 1: output channel A.
- `b_valid` out 1, `b_data` out N, `b_ready` in 1: output channel B.

## Operation
- Each output has its own 2-entry FIFO holding N-bit words, with a read pointer, a write pointer and a 2-bit count (0..2).
- Accept rule: `in_ready` = !`flush` && (`in_sel` ? B count != 2 : A count != 2).
  - `in_ready` depends combinationally on `in_sel`, `flush` and registered counts only.
  - It never depends on `in_valid`.
- Push: on `in_valid && in_ready`, write `in_data` into the selected FIFO at the write pointer, then advance the pointer mod 2. The other FIFO is untouched.
- Pop: `x_valid` = (count_x != 0); `x_data` = entry at the read pointer. On `x_valid && x_ready`, advance the read pointer mod 2.
- Simultaneous push and pop on the same FIFO:
  - Count is unchanged.
  - This is legal at count 1.
  - At count 2 no push occurs, because `in_ready` is low even if a pop happens that cycle. There is no same-cycle pass-through of freed space.
- Ordering is preserved within each output. There is no ordering relation between A and B.
- Output channels are independent. A stalled `a_ready` never blocks traffic destined for B.
- `flush` (when `rst`=0) zeroes both counts and both pointers at the next edge. Pops and pushes in the flush cycle are discarded.
- Data storage is not reset. `x_data` is don't-care while `x_valid`=0.
- `in_data`/`in_sel` are don't-care while `in_valid`=0.

## Timing
- Reset values after `rst` is high at an edge:
  - `a_valid`=0, `b_valid`=0.
  - All counts and pointers are 0.
  - `in_ready`=1 in the following cycle whenever `flush`=0.
- While `rst`=1, `in_ready` is still computed from the counts and may be high. Handshakes in a reset cycle are discarded.
- Latency: a word accepted at edge k is visible on `x_valid`/`x_data` in the cycle after edge k (1 cycle). There is no combinational path from `in_*` to `x_valid`/`x_data`.
- Throughput: 1 word/cycle to a given output while that consumer holds `x_ready`=1 continuously. Count settles at 1.
- `x_valid` may assert with `x_ready` low. Once asserted, `x_valid` and `x_data` hold until popped, flushed or reset.
- Reset mid-stream: in-flight words in both FIFOs are dropped, with no partial pops.
- Assertion: count never exceeds 2 and never underflows. Pop is impossible at count 0, because `x_valid`=0 there.

## Structure
- Sub-module `demux_fifo2 #(N)`: 2-entry synchronous FIFO.
  - Ports: `clk`, `rst`, `flush`, `push`, `push_data`, `full`, `pop`, `empty`, `head_data`.
  - Instantiated twice.
- The top level holds only the select/ready logic and the push/pop enables.
- Shared package `demux_pkg`:
  - `SEL_A` = 1'b0, `SEL_B` = 1'b1.
  - `FIFO_DEPTH` = 2.
  - Count type `logic [1:0]`.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1, `in_sel`=0, `in_data`=32'hDEAD_BEEF → after release `a_valid`=`b_valid`=0; the first post-reset accept of 32'h1 appears on `a_data` one cycle later.
- Steering: push 32'h11 (sel 0), 32'h22 (sel 1), 32'h33 (sel 0) back to back with both readys high → A emits 32'h11 then 32'h33, B emits 32'h22, each 1 cycle after its accept.
- Backpressure isolation: `a_ready`=0; push 32'hA0, 32'hA1 to A, then 32'hA2 to A, then 32'hB0 to B → `in_ready`=0 for 32'hA2 until `a_ready` rises, and 32'hB0 must wait behind it in input order. Separately, with A full, 32'hB0 offered directly is accepted.
- Full-rate streaming: 100 consecutive words to B with `b_ready`=1 → `in_ready` stays 1, B count ≤1, B outputs 0..99 in order with 1-cycle latency.
- Full with simultaneous pop: fill A to 2 (32'h5, 32'h6), then in one cycle raise `a_ready`=1 and offer 32'h7 to A → 32'h5 pops, 32'h7 is not accepted, and it is accepted the next cycle.
- Flush: A holds 2 words, B holds 1, and a pop plus a push are attempted in the flush cycle → next cycle both valids are 0 and `in_ready`=1; the next word 32'h9 to B appears alone on `b_data`.

Source files
------------

// File: rtl/nbit_demux_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer: select
// encodings, FIFO geometry and the pointer helper.
package demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int FIFO_DEPTH = 32'sd2;

    typedef logic [1:0] count_t;

    localparam count_t COUNT_EMPTY = 2'd0;
    localparam count_t COUNT_FULL  = 2'd2;

    // Two entries, so advancing a pointer mod 2 is a toggle.
    function automatic logic ptr_next(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/nbit_demux_reg_fifo2.sv
// Two-entry synchronous FIFO used for each output channel of nbit_demux_reg.
// Push is ignored when full and pop is ignored when empty.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [N-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [N-1:0] head_data
);

    logic [N-1:0] mem_r [FIFO_DEPTH];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    count_t       count_r;
    logic         push_en_s;
    logic         pop_en_s;

    assign full      = (count_r == COUNT_FULL);
    assign empty     = (count_r == COUNT_EMPTY);
    assign head_data = mem_r[rd_ptr_r];

    // Qualify requests against occupancy so count can never over/underflow.
    always_comb begin
        push_en_s = push && !full;
        pop_en_s  = pop && !empty;
    end

    // Pointers and occupancy; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= COUNT_EMPTY;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_en_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Data storage carries no reset; entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/nbit_demux_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to output A or B
// through an independent 2-entry FIFO so one stalled consumer never blocks the other.
module nbit_demux_reg
    import demux_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    output logic         in_ready,
    output logic         a_valid,
    output logic [N-1:0] a_data,
    input  logic         a_ready,
    output logic         b_valid,
    output logic [N-1:0] b_data,
    input  logic         b_ready
);

    logic a_full_s;
    logic a_empty_s;
    logic b_full_s;
    logic b_empty_s;
    logic a_push_s;
    logic b_push_s;
    logic a_pop_s;
    logic b_pop_s;

    // Ready looks only at the selected FIFO's registered fullness, so a pop
    // in the same cycle never frees space for the incoming word.
    always_comb begin
        in_ready = 1'b0;
        a_push_s = 1'b0;
        b_push_s = 1'b0;
        if (flush) begin
            in_ready = 1'b0;
        end else if (in_sel == SEL_B) begin
            in_ready = !b_full_s;
        end else begin
            in_ready = !a_full_s;
        end
        if (in_valid && in_ready) begin
            if (in_sel == SEL_B) begin
                b_push_s = 1'b1;
            end else begin
                a_push_s = 1'b1;
            end
        end else begin
            a_push_s = 1'b0;
            b_push_s = 1'b0;
        end
    end

    // Output handshakes; each channel pops only from its own FIFO.
    always_comb begin
        a_valid = !a_empty_s;
        b_valid = !b_empty_s;
        a_pop_s = a_valid && a_ready;
        b_pop_s = b_valid && b_ready;
    end

    demux_fifo2 #(.N(N)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (a_push_s),
        .push_data (in_data),
        .full      (a_full_s),
        .pop       (a_pop_s),
        .empty     (a_empty_s),
        .head_data (a_data)
    );

    demux_fifo2 #(.N(N)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (b_push_s),
        .push_data (in_data),
        .full      (b_full_s),
        .pop       (b_pop_s),
        .empty     (b_empty_s),
        .head_data (b_data)
    );

endmodule
